ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 CLK  in  1  system clock; all state updates on rising edge.
REQ-002 RST  in  1  reset, synchronous, active-high.
REQ-003 CPU_REQ  in  1  CPU (sequence controller) access request; CPU_WE in 1 (1=write); CPU_ADDR in 7; CPU_WDATA in 8.
REQ-004 CPU_GNT  out  1  CPU owns RAM for current transaction; CPU_ACK out 1 one-cycle completion pulse; CPU_RDATA out 8 read result.
REQ-005 DMA_REQ, DMA_WE, DMA_ADDR[6:0], DMA_WDATA[7:0] in; DMA_GNT, DMA_ACK, DMA_RDATA[7:0] out; meanings as CPU set, for the port/DMA requester.
REQ-006 RAM_CS, RAM_OE, RAM_WE  out  1 each  RAM chip select, output enable, write strobe.
REQ-007 RAM_ADDR out 7, RAM_WDATA out 8, RAM_RDATA in 8  RAM address/data buses.
REQ-008 BUSY  out  1  high whenever state is not IDLE.

Function
REQ-009 FSM states SHALL be IDLE, SETUP, STROBE, ACK; all outputs registered.
REQ-010 IDLE: if any REQ high, select winner, latch its WE/ADDR/WDATA and requester ID, go to SETUP; else stay IDLE.
REQ-011 SETUP: RAM_CS=1, RAM_ADDR/RAM_WDATA from latched values, winner GNT=1, RAM_OE=RAM_WE=0; go to STROBE.
REQ-012 STROBE: RAM_CS=1; RAM_OE=1 if read, RAM_WE=1 if write (never both); read data captured from RAM_RDATA at end of cycle; go to ACK.
REQ-013 ACK: RAM_CS/OE/WE=0, winner GNT=1, winner ACK=1 for exactly one cycle, winner RDATA valid (write: RDATA unchanged); go to IDLE.
REQ-014 Latency: REQ sampled high in IDLE at edge N -> ACK high in cycle N+3; minimum 4 cycles per transaction, next transaction may start in the IDLE cycle after ACK.
REQ-015 Requester SHALL hold REQ until ACK seen and drop or re-present it on the edge ACK is sampled; arbiter never re-samples REQ outside IDLE.
REQ-016 REQ dropped or ADDR/WDATA changed after IDLE: transaction SHALL complete with latched values; no abort.
REQ-017 At most one GNT high at any time; GNT low in IDLE; non-winner ACK stays 0.
REQ-018 xx_RDATA SHALL hold last read value until the next read completing to that requester.
REQ-019 Simultaneous CPU_REQ and DMA_REQ in IDLE: winner per REQ-024/025.
REQ-020 RAM_ADDR/RAM_WDATA hold last driven values outside SETUP/STROBE.

Reset
REQ-021 RST high at an edge SHALL force IDLE and all outputs 0 (GNT, ACK, RAM_CS/OE/WE, RAM_ADDR, RAM_WDATA, both RDATA, BUSY) by that edge, irrespective of state.
REQ-022 Reset mid-transaction SHALL abort it with no ACK issued; requester must re-request.
REQ-023 Round-robin last-winner pointer SHALL reset to DMA (so CPU wins first tie).

Configuration
REQ-024 Macro RAM_ARB_RR_EN defined: ties resolved round-robin; winner is requester not granted last; pointer updates on each grant.
REQ-025 Macro RAM_ARB_RR_EN undefined: fixed priority, CPU always wins ties; DMA may starve; no pointer register.

Verification
REQ-026 RST=1 two cycles mid-STROBE of CPU read -> next cycle all outputs 0, BUSY=0, no CPU_ACK.
REQ-027 CPU write ADDR=7'h06 WDATA=8'hA5 alone -> SETUP CS=1, STROBE WE=1 OE=0 RAM_ADDR=06 RAM_WDATA=A5, CPU_ACK exactly 3 cycles after request edge.
REQ-028 DMA read ADDR=7'h28 with RAM model returning 8'h3C -> DMA_ACK pulse, DMA_RDATA=3C, CPU_RDATA unchanged, RAM_OE high only in STROBE.
REQ-029 Both REQ held continuously for 4 transactions -> with RAM_ARB_RR_EN grants CPU,DMA,CPU,DMA; without, CPU,CPU,CPU,CPU and DMA_GNT never high.
REQ-030 CPU_REQ dropped and CPU_ADDR changed to 7'h78 in SETUP of access to 7'h60 -> STROBE still uses 60, CPU_ACK still issued.
REQ-031 Back-to-back CPU reads 7'h00 then 7'h01 -> second SETUP exactly 2 cycles after first ACK edge... i.e. IDLE one cycle between; GNT never overlaps.

Source files
------------

// File: rtl/ram_arbiter_if.sv
// Bus bundle between ram_arbiter, its two requesters (CPU, DMA) and the RAM.
// slave: arbiter view; master: requester/RAM view.
interface ram_arbiter_if;
  logic       cpu_req;
  logic       cpu_we;
  logic [6:0] cpu_addr;
  logic [7:0] cpu_wdata;
  logic       cpu_gnt;
  logic       cpu_ack;
  logic [7:0] cpu_rdata;

  logic       dma_req;
  logic       dma_we;
  logic [6:0] dma_addr;
  logic [7:0] dma_wdata;
  logic       dma_gnt;
  logic       dma_ack;
  logic [7:0] dma_rdata;

  logic       ram_cs;
  logic       ram_oe;
  logic       ram_we;
  logic [6:0] ram_addr;
  logic [7:0] ram_wdata;
  logic [7:0] ram_rdata;

  logic       busy;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    input  ram_rdata,
    output cpu_gnt, cpu_ack, cpu_rdata,
    output dma_gnt, dma_ack, dma_rdata,
    output ram_cs, ram_oe, ram_we, ram_addr, ram_wdata,
    output busy
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output dma_req, dma_we, dma_addr, dma_wdata,
    output ram_rdata,
    input  cpu_gnt, cpu_ack, cpu_rdata,
    input  dma_gnt, dma_ack, dma_rdata,
    input  ram_cs, ram_oe, ram_we, ram_addr, ram_wdata,
    input  busy
  );
endinterface

// File: rtl/ram_arbiter.sv
// Two-requester (CPU/DMA) single-port RAM arbiter, IDLE/SETUP/STROBE/ACK cycle.
// Define RAM_ARB_RR_EN for round-robin ties; otherwise CPU has fixed priority.
module ram_arbiter (
  input  logic          clk,
  input  logic          rst,
  ram_arbiter_if.slave  bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] STROBE = 2'd2;
  localparam logic [1:0] ACK    = 2'd3;

  logic [1:0] state;
  logic       sel_dma;
  logic       lat_we;
  logic       dma_wins;

`ifdef RAM_ARB_RR_EN
  logic last_dma;

  always_comb begin
    dma_wins = bus.dma_req && (!bus.cpu_req || !last_dma);
  end

  always_ff @(posedge clk) begin
    if (rst)
      last_dma <= 1'b1;
    else if (state == IDLE && (bus.cpu_req || bus.dma_req))
      last_dma <= dma_wins;
  end
`else
  always_comb begin
    dma_wins = bus.dma_req && !bus.cpu_req;
  end
`endif

  // ram_addr/ram_wdata double as the latched address/data of the transaction
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      sel_dma       <= 1'b0;
      lat_we        <= 1'b0;
      bus.cpu_gnt   <= 1'b0;
      bus.cpu_ack   <= 1'b0;
      bus.cpu_rdata <= '0;
      bus.dma_gnt   <= 1'b0;
      bus.dma_ack   <= 1'b0;
      bus.dma_rdata <= '0;
      bus.ram_cs    <= 1'b0;
      bus.ram_oe    <= 1'b0;
      bus.ram_we    <= 1'b0;
      bus.ram_addr  <= '0;
      bus.ram_wdata <= '0;
      bus.busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cpu_req || bus.dma_req) begin
            sel_dma       <= dma_wins;
            lat_we        <= dma_wins ? bus.dma_we    : bus.cpu_we;
            bus.ram_addr  <= dma_wins ? bus.dma_addr  : bus.cpu_addr;
            bus.ram_wdata <= dma_wins ? bus.dma_wdata : bus.cpu_wdata;
            bus.cpu_gnt   <= !dma_wins;
            bus.dma_gnt   <= dma_wins;
            bus.ram_cs    <= 1'b1;
            bus.busy      <= 1'b1;
            state         <= SETUP;
          end
        end
        SETUP: begin
          bus.ram_oe <= !lat_we;
          bus.ram_we <= lat_we;
          state      <= STROBE;
        end
        STROBE: begin
          bus.ram_cs <= 1'b0;
          bus.ram_oe <= 1'b0;
          bus.ram_we <= 1'b0;
          if (!lat_we) begin
            if (sel_dma)
              bus.dma_rdata <= bus.ram_rdata;
            else
              bus.cpu_rdata <= bus.ram_rdata;
          end
          bus.cpu_ack <= !sel_dma;
          bus.dma_ack <= sel_dma;
          state       <= ACK;
        end
        ACK: begin
          bus.cpu_gnt <= 1'b0;
          bus.dma_gnt <= 1'b0;
          bus.cpu_ack <= 1'b0;
          bus.dma_ack <= 1'b0;
          bus.busy    <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed table, corner sequences and
// randomized transactions against a transaction-level reference model.
module tb_ram_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ram_arbiter_if bus();
  ram_arbiter dut (.clk(clk), .rst(rst), .bus(bus));

  // RAM device: contents reload to a known pattern while reset is held
  logic [7:0] mem [128];
  assign bus.ram_rdata = (bus.ram_cs && bus.ram_oe) ? mem[bus.ram_addr] : 8'h00;
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 128; i++) mem[i] <= 8'(i) ^ 8'h14;
    end else if (bus.ram_cs && bus.ram_we) begin
      mem[bus.ram_addr] <= bus.ram_wdata;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0)
      chk("gnt_ack_excl", {61'd0, bus.cpu_gnt & bus.dma_gnt, bus.cpu_ack & ~bus.cpu_gnt,
                            bus.dma_ack & ~bus.dma_gnt}, 64'd0);
  end

  // Reference model: memory image, last read per requester, last grant
  logic [7:0] ref_mem [128];
  logic [7:0] ref_crd, ref_drd;
  bit         ref_last_dma;

  task automatic model_reset();
    for (int i = 0; i < 128; i++) ref_mem[i] = 8'(i) ^ 8'h14;
    ref_crd = 8'h00;
    ref_drd = 8'h00;
    ref_last_dma = 1'b1;
  endtask

  function automatic bit pick_dma(input bit c, input bit d);
    if (c && d) begin
`ifdef RAM_ARB_RR_EN
      return !ref_last_dma;
`else
      return 1'b0;
`endif
    end
    return d;
  endfunction

  function automatic logic [63:0] all_outs();
    return {25'd0, bus.cpu_gnt, bus.cpu_ack, bus.cpu_rdata, bus.dma_gnt, bus.dma_ack,
            bus.dma_rdata, bus.ram_cs, bus.ram_oe, bus.ram_we, bus.ram_addr,
            bus.ram_wdata, bus.busy};
  endfunction

  task automatic drop_reqs();
    bus.cpu_req = 1'b0;
    bus.dma_req = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    drop_reqs();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outs", all_outs(), 64'd0);
    rst = 1'b0;
    model_reset();
  endtask

  // Starts at #1 after an edge with the arbiter in IDLE; ends the same way.
  task automatic run_txn(input bit cr, input bit dr,
                         input bit cw, input logic [6:0] ca, input logic [7:0] cd,
                         input bit dw, input logic [6:0] da, input logic [7:0] dd,
                         input bit exp_dma, input logic [7:0] exp_rd,
                         input bit hold, input bit perturb);
    bit         we_l;
    logic [6:0] a;
    logic [7:0] wd;
    bus.cpu_req = cr; bus.cpu_we = cw; bus.cpu_addr = ca; bus.cpu_wdata = cd;
    bus.dma_req = dr; bus.dma_we = dw; bus.dma_addr = da; bus.dma_wdata = dd;
    we_l = exp_dma ? dw : cw;
    a    = exp_dma ? da : ca;
    wd   = exp_dma ? dd : cd;

    @(posedge clk); #1;
    chk("setup_ctrl", {bus.busy, bus.ram_cs, bus.ram_oe, bus.ram_we, bus.cpu_gnt, bus.dma_gnt,
                       bus.cpu_ack, bus.dma_ack}, {4'b1100, !exp_dma, exp_dma, 2'b00});
    chk("setup_bus", {bus.ram_addr, bus.ram_wdata}, {a, wd});
    if (perturb) begin
      drop_reqs();
      bus.cpu_addr = 7'h78; bus.dma_addr = 7'h78;
      bus.cpu_wdata = ~cd;  bus.dma_wdata = ~dd;
    end

    @(posedge clk); #1;
    chk("strobe_ctrl", {bus.busy, bus.ram_cs, bus.ram_oe, bus.ram_we, bus.cpu_gnt, bus.dma_gnt,
                        bus.cpu_ack, bus.dma_ack}, {2'b11, !we_l, we_l, !exp_dma, exp_dma, 2'b00});
    chk("strobe_bus", {bus.ram_addr, bus.ram_wdata}, {a, wd});

    @(posedge clk); #1;
    if (we_l) ref_mem[a] = wd;
    else if (exp_dma) ref_drd = exp_rd;
    else ref_crd = exp_rd;
    ref_last_dma = exp_dma;
    chk("ack_ctrl", {bus.busy, bus.ram_cs, bus.ram_oe, bus.ram_we, bus.cpu_gnt, bus.dma_gnt,
                     bus.cpu_ack, bus.dma_ack}, {4'b1000, !exp_dma, exp_dma, !exp_dma, exp_dma});
    chk("ack_rdata", {bus.cpu_rdata, bus.dma_rdata}, {ref_crd, ref_drd});
    if (!hold) drop_reqs();

    @(posedge clk); #1;
    chk("idle_ctrl", {bus.busy, bus.ram_cs, bus.ram_oe, bus.ram_we, bus.cpu_gnt, bus.dma_gnt,
                      bus.cpu_ack, bus.dma_ack}, 64'd0);
    chk("idle_bus_hold", {bus.ram_addr, bus.ram_wdata}, {a, wd});
  endtask

  typedef struct {
    bit         cr, dr, cw;
    logic [6:0] ca;
    logic [7:0] cd;
    bit         dw;
    logic [6:0] da;
    logic [7:0] dd;
    bit         exp_dma;
    logic [7:0] exp_rd;
  } vec_t;

  vec_t vecs [8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b1, 1'b0, 1'b1, 7'h06, 8'hA5, 1'b0, 7'h11, 8'h22, 1'b0, 8'h00};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 7'h06, 8'h00, 1'b1, 7'h12, 8'h33, 1'b0, 8'hA5};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 7'h07, 8'h44, 1'b0, 7'h28, 8'h00, 1'b1, 8'h3C};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 7'h08, 8'h55, 1'b1, 7'h7F, 8'hFF, 1'b1, 8'h00};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 7'h09, 8'h66, 1'b0, 7'h7F, 8'h00, 1'b1, 8'hFF};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 7'h00, 8'h00, 1'b1, 7'h13, 8'h77, 1'b0, 8'h14};
    vecs[6] = '{1'b1, 1'b0, 1'b1, 7'h01, 8'h5A, 1'b0, 7'h14, 8'h88, 1'b0, 8'h00};
    vecs[7] = '{1'b0, 1'b1, 1'b0, 7'h0A, 8'h99, 1'b0, 7'h01, 8'h00, 1'b1, 8'h5A};

    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.dma_req = 1'b0; bus.dma_we = 1'b0; bus.dma_addr = '0; bus.dma_wdata = '0;
    apply_reset();

    foreach (vecs[i])
      run_txn(vecs[i].cr, vecs[i].dr, vecs[i].cw, vecs[i].ca, vecs[i].cd,
              vecs[i].dw, vecs[i].da, vecs[i].dd, vecs[i].exp_dma, vecs[i].exp_rd, 1'b0, 1'b0);

    // Back-to-back CPU reads: request re-presented in the ACK cycle
    run_txn(1'b1, 1'b0, 1'b0, 7'h00, 8'h00, 1'b0, 7'h00, 8'h00, 1'b0, 8'h14, 1'b1, 1'b0);
    run_txn(1'b1, 1'b0, 1'b0, 7'h01, 8'h00, 1'b0, 7'h00, 8'h00, 1'b0, 8'h5A, 1'b0, 1'b0);

    // Request dropped and address/data changed during SETUP
    run_txn(1'b1, 1'b0, 1'b1, 7'h60, 8'h77, 1'b0, 7'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
    run_txn(1'b1, 1'b0, 1'b0, 7'h60, 8'h00, 1'b0, 7'h00, 8'h00, 1'b0, 8'h77, 1'b0, 1'b0);
    run_txn(1'b1, 1'b0, 1'b0, 7'h78, 8'h00, 1'b0, 7'h00, 8'h00, 1'b0, 8'h6C, 1'b0, 1'b0);

    // Reset held two cycles starting mid-STROBE of a CPU read
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 7'h05;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_reset_strobe", {bus.ram_cs, bus.ram_oe, bus.ram_we}, 3'b110);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("reset_mid_strobe", all_outs(), 64'd0);
    @(posedge clk); #1;
    chk("reset_hold", all_outs(), 64'd0);
    rst = 1'b0;
    drop_reqs();
    model_reset();
    @(posedge clk); #1;
    chk("post_reset_idle", all_outs(), 64'd0);

    // Both requesting for four consecutive transactions
    for (int i = 0; i < 4; i++) begin
      bit ed;
`ifdef RAM_ARB_RR_EN
      ed = (i % 2) == 1;
`else
      ed = 1'b0;
`endif
      run_txn(1'b1, 1'b1, 1'b0, 7'h10, 8'h00, 1'b0, 7'h20, 8'h00,
              ed, ed ? 8'h34 : 8'h04, i != 3, 1'b0);
    end

    // Randomized traffic against the reference model
    for (int i = 0; i < 60; i++) begin
      bit cr, dr, cw, dw, ed, hold, pert;
      logic [6:0] ca, da;
      logic [7:0] cd, dd;
      cr = 1'($urandom); dr = 1'($urandom);
      if (!cr && !dr) cr = 1'b1;
      cw = 1'($urandom); dw = 1'($urandom);
      ca = 7'($urandom_range(0, 15)); da = 7'($urandom_range(0, 15));
      cd = 8'($urandom); dd = 8'($urandom);
      hold = 1'($urandom);
      pert = ($urandom_range(0, 3) == 0);
      ed = pick_dma(cr, dr);
      run_txn(cr, dr, cw, ca, cd, dw, da, dd, ed, ref_mem[ed ? da : ca], hold, pert);
    end

    drop_reqs();
    @(posedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
